// File: rtl/yutorina_if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches one word per ack,
// applies decoder branches (one delay slot) and flush redirects. Optional: IF_BUS_TIMEOUT_EN.
module yutorina_if_stage #(
  parameter logic [29:0] RESET_VECTOR   = 30'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] if_insn,
  output logic [29:0] if_pc,
  output logic        if_en,
  output logic        busy,
  output logic        if_bus_err
);

  localparam logic [31:0] ISA_NOP = 32'h0000_0000;

  typedef enum logic {SEQ, BR_PEND} state_t;

  function automatic logic [29:0] inc_pc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

  state_t      state_q, state_d;
  logic [29:0] pc_p0, pc_p0_d;
  logic [29:0] br_target_q, br_target_d;
  logic [31:0] insn_p1, insn_p1_d;
  logic [29:0] npc_p1, npc_p1_d;
  logic        vld_p1, vld_p1_d;
`ifdef IF_BUS_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_p1, err_p1_d;
`endif

  assign imem_req  = !stall && !flush && reset_;
  assign imem_addr = pc_p0;
  assign busy      = imem_req && !imem_rdy;
  assign if_insn   = insn_p1;
  assign if_pc     = npc_p1;
  assign if_en     = vld_p1;
`ifdef IF_BUS_TIMEOUT_EN
  assign if_bus_err = err_p1;
`else
  assign if_bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_p0_d     = pc_p0;
    br_target_d = br_target_q;
    insn_p1_d   = insn_p1;
    npc_p1_d    = npc_p1;
    vld_p1_d    = vld_p1;
`ifdef IF_BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_p1_d    = err_p1;
`endif
    if (flush) begin
      pc_p0_d   = new_pc;
      insn_p1_d = ISA_NOP;
      vld_p1_d  = 1'b0;
      state_d   = SEQ;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_d     = '0;
      err_p1_d  = 1'b0;
`endif
    end else if (stall) begin
`ifdef IF_BUS_TIMEOUT_EN
      tmo_d = '0;
`endif
    end else if (imem_rdy) begin
      insn_p1_d = imem_rd_data;
      npc_p1_d  = inc_pc(pc_p0);
      vld_p1_d  = 1'b1;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_d     = '0;
      err_p1_d  = 1'b0;
`endif
      if (state_q == BR_PEND) begin
        pc_p0_d = br_target_q;
        state_d = SEQ;
      end else if (br_taken) begin
        pc_p0_d = br_addr;
      end else begin
        pc_p0_d = inc_pc(pc_p0);
      end
    end else begin
      insn_p1_d = ISA_NOP;
      vld_p1_d  = 1'b0;
      // Remember the target so the delay slot is still fetched from the current pc.
      if (state_q == SEQ && br_taken) begin
        br_target_d = br_addr;
        state_d     = BR_PEND;
      end
`ifdef IF_BUS_TIMEOUT_EN
      err_p1_d = 1'b0;
      if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
        vld_p1_d = 1'b1;
        err_p1_d = 1'b1;
        npc_p1_d = inc_pc(pc_p0);
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
`endif
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= SEQ;
      pc_p0       <= RESET_VECTOR;
      br_target_q <= '0;
      insn_p1     <= ISA_NOP;
      npc_p1      <= RESET_VECTOR;
      vld_p1      <= 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_q       <= '0;
      err_p1      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_p0       <= pc_p0_d;
      br_target_q <= br_target_d;
      insn_p1     <= insn_p1_d;
      npc_p1      <= npc_p1_d;
      vld_p1      <= vld_p1_d;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_p1      <= err_p1_d;
`endif
    end
  end

endmodule

// File: tb/tb_yutorina_if_stage.sv
// Directed bench for yutorina_if_stage (default build): expected IF/ID contents are queued
// when each cycle is driven and popped one clock later when the register updates.
`timescale 1ns/1ps
module tb_yutorina_if_stage;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush, br_taken, imem_rdy;
  logic [29:0] new_pc, br_addr;
  logic [31:0] imem_rd_data;
  logic        imem_req, if_en, busy, if_bus_err;
  logic [29:0] imem_addr, if_pc;
  logic [31:0] if_insn;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] insn;
    logic [29:0] pc;
    logic        en;
  } exp_t;
  exp_t sb[$];

  yutorina_if_stage dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rd_data(imem_rd_data), .if_insn(if_insn), .if_pc(if_pc),
    .if_en(if_en), .busy(busy), .if_bus_err(if_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check fetch port, queue expectation, check IF/ID after posedge.
  task automatic cyc(input logic st, input logic fl, input logic [29:0] npc,
                     input logic bt, input logic [29:0] ba, input logic rdy,
                     input logic [31:0] d, input logic [29:0] exp_addr,
                     input logic [31:0] e_insn, input logic [29:0] e_pc, input logic e_en);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; new_pc = npc; br_taken = bt; br_addr = ba;
    imem_rdy = rdy; imem_rd_data = d;
    #1;
    chk32("imem_req", 32'(imem_req), 32'(!st && !fl));
    chk32("busy", 32'(busy), 32'(!st && !fl && !rdy));
    if (!st && !fl) chk32("imem_addr", 32'(imem_addr), 32'(exp_addr));
    sb.push_back('{insn: e_insn, pc: e_pc, en: e_en});
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk32("if_insn", if_insn, e.insn);
      chk32("if_pc", 32'(if_pc), 32'(e.pc));
      chk32("if_en", 32'(if_en), 32'(e.en));
      chk32("if_bus_err", 32'(if_bus_err), 32'd0);
    end
  endtask

  initial begin
    stall = 0; flush = 0; br_taken = 0; imem_rdy = 0;
    new_pc = '0; br_addr = '0; imem_rd_data = '0;
    reset_ = 1'b1;
    #1 reset_ = 1'b0;
    #2;
    chk32("rst_if_insn", if_insn, 32'h0);
    chk32("rst_if_pc", 32'(if_pc), 32'h0);
    chk32("rst_if_en", 32'(if_en), 32'h0);
    chk32("rst_imem_req", 32'(imem_req), 32'h0);
    chk32("rst_imem_addr", 32'(imem_addr), 32'h0);
    chk32("rst_busy", 32'(busy), 32'h0);
    chk32("rst_bus_err", 32'(if_bus_err), 32'h0);
    @(negedge clk);
    reset_ = 1'b1;

    // Sequential fetch, one word per cycle
    for (int n = 0; n < 5; n++)
      cyc(0, 0, 0, 0, 0, 1, 32'h1111_0000 + n, 30'(n), 32'h1111_0000 + n, 30'(n + 1), 1);
    // Branch on ack of address 5: word@5 is the delay slot, then 0x100
    cyc(0, 0, 0, 1, 30'h100, 1, 32'h1111_0005, 30'd5, 32'h1111_0005, 30'd6, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'hAAAA_0100, 30'h100, 32'hAAAA_0100, 30'h101, 1);
    // Flush to 7 (ready high but no request, so nothing captured)
    cyc(0, 1, 30'd7, 0, 0, 1, 32'hBAD0_0001, 30'd0, 32'h0, 30'h101, 0);
    // Branch while address 7 is unacked: three bubbles, delay slot, then 0x200
    cyc(0, 0, 0, 1, 30'h200, 0, 32'hBAD0_0002, 30'd7, 32'h0, 30'h101, 0);
    cyc(0, 0, 0, 1, 30'h333, 0, 32'hBAD0_0003, 30'd7, 32'h0, 30'h101, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'hBAD0_0004, 30'd7, 32'h0, 30'h101, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h7777_0007, 30'd7, 32'h7777_0007, 30'd8, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 30'h200, 32'hDEAD_BEEF, 30'h201, 1);
    // Stall four cycles: everything frozen, branch ignored
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 1, 30'h3AB, 1, 32'hBAD0_0010, 30'd0, 32'hDEAD_BEEF, 30'h201, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h5555_0201, 30'h201, 32'h5555_0201, 30'h202, 1);
    // Flush during stall wins
    cyc(1, 1, 30'h40, 0, 0, 1, 32'hBAD0_0020, 30'd0, 32'h0, 30'h202, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h4040_4040, 30'h40, 32'h4040_4040, 30'h41, 1);
    // PC wrap at the top of the address space
    cyc(0, 1, 30'h3FFF_FFFF, 0, 0, 1, 32'hBAD0_0030, 30'd0, 32'h0, 30'h41, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_0000, 30'h3FFF_FFFF, 32'hFFFF_0000, 30'd0, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_1234, 30'd0, 32'h0000_1234, 30'd1, 1);

    // Reset asserted mid-transfer (request pending, not acked)
    @(negedge clk);
    imem_rdy = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    chk32("mid_rst_if_en", 32'(if_en), 32'h0);
    chk32("mid_rst_if_insn", if_insn, 32'h0);
    chk32("mid_rst_if_pc", 32'(if_pc), 32'h0);
    chk32("mid_rst_imem_addr", 32'(imem_addr), 32'h0);
    chk32("mid_rst_imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    reset_ = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, 32'hCAFE_0000, 30'd0, 32'hCAFE_0000, 30'd1, 1);

    // Bus never answers: waits indefinitely, no bus error in this build
    for (int k = 0; k < 300; k++)
      cyc(0, 0, 0, 0, 0, 0, 32'hBAD0_0040, 30'd1, 32'h0, 30'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yutorina_if_stage.md
Name: yutorina_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and issues word fetches on the instruction-memory port.
- Registers `if_insn`, `if_pc` and `if_en` for the instruction decoder directly downstream.
- Applies redirects from the decoder (`br_taken`/`br_addr`, one delay slot) and from the exception/control unit (`flush`/`new_pc`).

Parameters:
- RESET_VECTOR, 30'h0000_0000, word address fetched first after reset.
- TIMEOUT_CYCLES, 255, consecutive un-acked request cycles before a bus error (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- reset_  in  1  asynchronous, active-low reset.
- stall  in  1  hold IF/ID register and PC.
- flush  in  1  discard fetch and pipeline register, redirect to new_pc.
- new_pc  in  30  redirect word address, valid with flush.
- br_taken  in  1  decoder branch/jump taken.
- br_addr  in  30  decoder branch target, valid with br_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  30  fetch word address (= pc).
- imem_rdy  in  1  transfer completes in a cycle with imem_req & imem_rdy.
- imem_rd_data  in  32  instruction word, valid with imem_rdy.
- if_insn  out  32  registered instruction to the decoder.
- if_pc  out  30  registered fetch address + 1 (sequential successor).
- if_en  out  1  if_insn is a real instruction.
- busy  out  1  fetch request outstanding, not acked this cycle.
- if_bus_err  out  1  fetch timeout marker (tied 0 without the optional feature).

Behaviour:
- Reset (async, reset_=0):
  - pc=RESET_VECTOR, state=SEQ.
  - if_insn=`ISA_NOP` (32'h0), if_pc=RESET_VECTOR, if_en=0, if_bus_err=0.
  - br_target=0, timeout count=0.
  - Reset may assert mid-transfer; any in-flight ack is lost.
- Request:
  - imem_req = !stall & !flush & reset_.
  - imem_addr = pc (combinational).
  - busy = imem_req & !imem_rdy.
- Priority each cycle: flush > stall > completed fetch > bubble.
- flush:
  - pc<=new_pc, if_insn<=NOP, if_en<=0, state<=SEQ, timeout count<=0.
  - A same-cycle ack is discarded.
  - flush overrides stall.
- stall (no flush): if_insn, if_pc, if_en, pc, state and br_target are all held.
- Completed fetch (req & rdy):
  - if_insn<=imem_rd_data, if_pc<=pc+1 (30-bit wrap, 30'h3FFF_FFFF+1 = 0), if_en<=1.
  - Next pc, state SEQ:
    - br_taken=1: pc<=br_addr. The word just fetched is the delay slot.
    - br_taken=0: pc<=pc+1.
  - Next pc, state BR_PEND: pc<=br_target, state<=SEQ.
- Bubble (req & !rdy):
  - if_insn<=NOP, if_en<=0, pc held.
  - br_taken=1 in SEQ: br_target<=br_addr, state<=BR_PEND, so the delay slot is still fetched from the current pc.
- br_taken:
  - Sampled only when !stall & !flush.
  - Ignored in BR_PEND; the decoder only sees bubbles there.
- Latency: ack in cycle N gives if_insn valid in cycle N+1. Back-to-back acks give one instruction per cycle.
- if_bus_err is 0 except as described under Optional Feature.

Optional Feature:
- Macro IF_BUS_TIMEOUT_EN.
- When defined:
  - Counter increments each cycle with imem_req & !imem_rdy; it clears on ack, stall, flush or reset.
  - When the count reaches TIMEOUT_CYCLES, the stage issues for one cycle: if_insn<=NOP, if_en<=1, if_bus_err<=1, if_pc<=pc+1.
  - pc and state are held, the counter clears, and fetch retries until upstream flushes.
- When undefined: no counter, a fetch waits indefinitely, and if_bus_err is constant 0.

Test Plan:
- Reset release with RESET_VECTOR=0 and imem_rdy=1 every cycle, data 32'h1111_0000+n -> imem_addr 0,1,2,…; if_insn follows one cycle later; if_pc 1,2,3; if_en=1 from the second cycle.
- br_taken=1, br_addr=30'h100 in the same cycle as the ack for address 5 -> if_insn=word@5 (delay slot) with if_pc=6, then imem_addr=30'h100.
- br_taken=1, br_addr=30'h200 while address 7 is unacked, imem_rdy low for 3 cycles -> state BR_PEND, three NOP bubbles with if_en=0; word@7 delivered on ack, next imem_addr=30'h200.
- stall high 4 cycles holding if_insn=32'hDEAD_BEEF -> imem_req=0, outputs frozen; release resumes at the held pc. flush with new_pc=30'h40 during stall -> if_en=0 next cycle and imem_addr=30'h40.
- pc=30'h3FFF_FFFF acked -> if_pc=0, next imem_addr=0. flush in the same cycle as an ack -> data discarded, if_en=0.
- IF_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_rdy stuck 0 -> one cycle with if_bus_err=1, if_en=1, if_insn=0, then retry at the same imem_addr; without the macro, if_bus_err stays 0 indefinitely.
